// File: rtl/log2_pkg.sv
// Shared width helpers and the elaboration-time table generator for the
// pipelined fixed-point log2.
package log2_pkg;

  localparam int LUT_GUARD = 8;
  localparam int LUT_PREC  = 30;

  function automatic int out_w(input int data_w, input int frac_w);
    return $clog2(data_w) + 2 + frac_w;
  endfunction

  function automatic int clz_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int r_bits(input int data_w, input int lut_aw);
    return data_w - 1 - lut_aw;
  endfunction

  // Integer-only log2(1 + j/2^lut_aw): square the mantissa repeatedly and
  // peel off one result bit per squaring, then round away the guard bits.
  function automatic int lut_entry(input int j, input int lut_aw, input int frac_w);
    logic [63:0] x;
    logic [63:0] acc;
    if (j >= (1 << lut_aw)) return 1 << frac_w;
    x   = 64'((1 << lut_aw) + j) << (LUT_PREC - lut_aw);
    acc = '0;
    for (int i = 0; i < frac_w + LUT_GUARD; i++) begin
      x   = (x * x) >> LUT_PREC;
      acc = acc << 1;
      if (x >= (64'd2 << LUT_PREC)) begin
        x   = x >> 1;
        acc = acc | 64'd1;
      end
    end
    acc = (acc + (64'd1 << (LUT_GUARD - 1))) >> LUT_GUARD;
    return int'(acc);
  endfunction

endpackage

// File: rtl/log2_fixed_point_interp_lzc.sv
// Combinational priority leading-zero counter; an all-zero word reports DATA_W.
module log2_lzc
  import log2_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]        data,
  output logic [clz_w(DATA_W)-1:0] clz
);

  localparam int CLZ_W = clz_w(DATA_W);

  // Scanning upward lets the highest set bit overwrite lower ones.
  always_comb begin
    clz = CLZ_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) clz = CLZ_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/log2_fixed_point_interp.sv
// Four-stage fixed-point log2 with LUT plus linear interpolation, gated by
// the shared i_VALID clock enable and a synchronous valid-pipeline flush.
module log2_fixed_point_interp
  import log2_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DATA_FRAC = 15,
  parameter int LUT_AW    = 5,
  parameter int FRAC_W    = 12
) (
  input  logic                             i_CLK,
  input  logic                             i_RSTn,
  input  logic                             i_VALID,
  input  logic                             i_DATA_VALID,
  input  logic                             i_FLUSH,
  input  logic [DATA_W-1:0]                i_DATA,
  output logic                             o_VALID,
  output logic                             o_LOG2_VALID,
  output logic [out_w(DATA_W, FRAC_W)-1:0] o_LOG2,
  output logic                             o_ZERO
);

  localparam int OUT_W  = out_w(DATA_W, FRAC_W);
  localparam int CLZ_W  = clz_w(DATA_W);
  localparam int R      = r_bits(DATA_W, LUT_AW);
  localparam int E_W    = CLZ_W + 2;
  localparam int T_W    = FRAC_W + 1;
  localparam int LUT_N  = (1 << LUT_AW) + 1;
  localparam int E_BIAS = DATA_W - 1 - DATA_FRAC;
  localparam logic [OUT_W-1:0] LOG2_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [T_W-1:0] lut_tab [LUT_N];

  for (genvar j = 0; j < LUT_N; j++) begin : g_lut
    assign lut_tab[j] = T_W'(lut_entry(j, LUT_AW, FRAC_W));
  end

  logic [DATA_W-1:0]     d1;
  logic                  v1, z1;
  logic [DATA_W-2:0]     m2;
  logic signed [E_W-1:0] e2;
  logic                  v2, z2;
  logic [T_W-1:0]        t0_3, t1_3;
  logic [R-1:0]          r3;
  logic signed [E_W-1:0] e3;
  logic                  v3, z3;

  logic [CLZ_W-1:0]      clz1;
  logic [DATA_W-2:0]     m1;
  logic                  norm_msb_unused;
  logic signed [E_W-1:0] e1;
  logic [LUT_AW:0]       k_lo, k_hi;
  logic [T_W-1:0]        delta3;
  logic [T_W+R-1:0]      prod3;
  logic [T_W-1:0]        frac3;
  logic [OUT_W-1:0]      log3;

  assign o_VALID = i_VALID;

  log2_lzc #(.DATA_W(DATA_W)) u_lzc (
    .data (d1),
    .clz  (clz1)
  );

  assign {norm_msb_unused, m1} = d1 << clz1;
  assign e1 = E_W'(E_BIAS) - E_W'(clz1);

  assign k_lo = {1'b0, m2[DATA_W-2 -: LUT_AW]};
  assign k_hi = k_lo + 1'b1;

  // Interpolation: the table is monotonic, so the delta is never negative.
  assign delta3 = t1_3 - t0_3;
  assign prod3  = (T_W+R)'(delta3) * (T_W+R)'(r3);
  assign frac3  = t0_3 + T_W'(prod3 >> R);
  assign log3   = ({{(OUT_W-E_W){e3[E_W-1]}}, e3} << FRAC_W) + OUT_W'(frac3);

  // Valid bits drop on a flush edge; every data register still loads.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      o_LOG2_VALID <= 1'b0;
    end else if (i_VALID) begin
      v1           <= i_DATA_VALID & ~i_FLUSH;
      v2           <= v1 & ~i_FLUSH;
      v3           <= v2 & ~i_FLUSH;
      o_LOG2_VALID <= v3 & ~i_FLUSH;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      d1   <= '0;
      z1   <= 1'b0;
      m2   <= '0;
      e2   <= '0;
      z2   <= 1'b0;
      t0_3 <= '0;
      t1_3 <= '0;
      r3   <= '0;
      e3   <= '0;
      z3   <= 1'b0;
    end else if (i_VALID) begin
      d1   <= i_DATA;
      z1   <= (i_DATA == '0);
      m2   <= m1;
      e2   <= e1;
      z2   <= z1;
      t0_3 <= lut_tab[k_lo];
      t1_3 <= lut_tab[k_hi];
      r3   <= m2[R-1:0];
      e3   <= e2;
      z3   <= z2;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_LOG2 <= '0;
      o_ZERO <= 1'b0;
    end else if (i_VALID) begin
      o_LOG2 <= z3 ? LOG2_MIN : log3;
      o_ZERO <= z3;
    end
  end

endmodule

// File: tb/tb_log2_fixed_point_interp.sv
// Bench for log2_fixed_point_interp: real-valued log2 model behind a
// 4-deep enabled-cycle history, plus directed literal vectors.
module tb_log2_fixed_point_interp;

  localparam int OUT_W   = 18;
  localparam int MIN_LOG = -(1 << (OUT_W - 1));

  logic              i_CLK        = 1'b0;
  logic              i_RSTn       = 1'b1;
  logic              i_VALID      = 1'b0;
  logic              i_DATA_VALID = 1'b0;
  logic              i_FLUSH      = 1'b0;
  logic [15:0]       i_DATA       = '0;
  logic              o_VALID;
  logic              o_LOG2_VALID;
  logic [OUT_W-1:0]  o_LOG2;
  logic              o_ZERO;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        v;
    logic        z;
    logic [15:0] d;
  } sample_t;

  sample_t     inflight[$];
  int          cap_mode = 0;
  int          cap_cnt  = 0;
  logic [15:0] vec [64];
  logic [15:0] dir_d   [5] = '{16'h8000, 16'h4000, 16'h0001, 16'hC000, 16'h0000};
  int          dir_log [5] = '{0, -4096, -61440, 2396, MIN_LOG};
  int          dir_zero[5] = '{0, 0, 0, 0, 1};

  log2_fixed_point_interp #(
    .DATA_W   (16),
    .DATA_FRAC(15),
    .LUT_AW   (5),
    .FRAC_W   (12)
  ) dut (
    .i_CLK        (i_CLK),
    .i_RSTn       (i_RSTn),
    .i_VALID      (i_VALID),
    .i_DATA_VALID (i_DATA_VALID),
    .i_FLUSH      (i_FLUSH),
    .i_DATA       (i_DATA),
    .o_VALID      (o_VALID),
    .o_LOG2_VALID (o_LOG2_VALID),
    .o_LOG2       (o_LOG2),
    .o_ZERO       (o_ZERO)
  );

  always #5 i_CLK = ~i_CLK;

  function automatic real ideal_log2(input logic [15:0] d);
    return ($ln(real'(int'(d))) - $ln(32768.0)) / $ln(2.0) * 4096.0;
  endfunction

  function automatic logic [15:0] rand_sample();
    logic [15:0] v;
    v = 16'($urandom);
    return v >> $urandom_range(0, 16);
  endfunction

  task automatic applyStimulus(input bit v, input bit dv, input bit fl, input logic [15:0] d);
    @(negedge i_CLK);
    i_VALID      = v;
    i_DATA_VALID = dv;
    i_FLUSH      = fl;
    i_DATA       = d;
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic checkNear(input logic [15:0] d, input int got);
    real ideal;
    real err;
    ideal = ideal_log2(d);
    err   = real'(got) - ideal;
    total++;
    if (err > 2.0 || err < -2.0) begin
      bad++;
      $display("[TB] FAIL log2_near: data=%h got %0d, want %0.3f +-2 (t=%0t)", d, got, ideal, $time);
    end
  endtask

  always @(negedge i_RSTn) inflight.delete();

  // Model: output after an enabled edge is the sample captured 3 enabled
  // edges earlier; a flush invalidates everything still in the pipe.
  sample_t cp_s;
  bit      cp_en;
  bit      cp_fl;
  bit      exp_v;
  always @(posedge i_CLK) begin
    cp_en    = i_VALID;
    cp_fl    = i_FLUSH;
    cp_s.v   = i_DATA_VALID && !i_FLUSH;
    cp_s.z   = (i_DATA == 16'h0);
    cp_s.d   = i_DATA;
    if (i_RSTn && cp_en) begin
      inflight.push_back(cp_s);
      if (inflight.size() > 4) void'(inflight.pop_front());
      if (cp_fl) foreach (inflight[i]) inflight[i].v = 1'b0;
    end
    #1;
    checkOutput("o_valid_pass", int'(o_VALID), int'(i_VALID));
    if (!i_RSTn) begin
      checkOutput("rst_valid", int'(o_LOG2_VALID), 0);
      checkOutput("rst_log2",  int'($signed(o_LOG2)), 0);
      checkOutput("rst_zero",  int'(o_ZERO), 0);
    end else begin
      exp_v = (inflight.size() == 4) && inflight[0].v;
      checkOutput("log2_valid", int'(o_LOG2_VALID), int'(exp_v));
      if (exp_v) begin
        checkOutput("zero_flag", int'(o_ZERO), int'(inflight[0].z));
        if (inflight[0].z) checkOutput("zero_log2", int'($signed(o_LOG2)), MIN_LOG);
        else               checkNear(inflight[0].d, int'($signed(o_LOG2)));
        if (cp_en && cap_mode != 0) cap_cnt++;
      end
    end
  end

  initial begin
    bit en;
    $display("[TB] start");
    #1 i_RSTn = 1'b0;
    repeat (2) @(negedge i_CLK);
    checkOutput("reset_valid", int'(o_LOG2_VALID), 0);
    checkOutput("reset_log2",  int'($signed(o_LOG2)), 0);
    checkOutput("reset_zero",  int'(o_ZERO), 0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;

    // Directed vectors with hand-computed results, each isolated
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, dir_d[i]);
      repeat (4) applyStimulus(1, 0, 0, 16'h1234);
      checkOutput("dir_valid", int'(o_LOG2_VALID), 1);
      checkOutput("dir_zero",  int'(o_ZERO), dir_zero[i]);
      checkOutput("dir_log2",  int'($signed(o_LOG2)), dir_log[i]);
    end

    for (int i = 0; i < 10000; i++) applyStimulus(1, 1, 0, rand_sample());
    repeat (5) applyStimulus(1, 0, 0, 16'h0);

    // Same 64 samples ungated, then under 50% i_VALID gating
    foreach (vec[i]) vec[i] = rand_sample();
    cap_cnt  = 0;
    cap_mode = 1;
    foreach (vec[i]) applyStimulus(1, 1, 0, vec[i]);
    repeat (5) applyStimulus(1, 0, 0, 16'h0);
    cap_mode = 0;
    checkOutput("ungated_count", cap_cnt, 64);
    cap_cnt  = 0;
    cap_mode = 2;
    foreach (vec[i]) begin
      do begin
        en = 1'($urandom_range(0, 1));
        applyStimulus(en, 1, 0, vec[i]);
      end while (!en);
    end
    for (int k = 0; k < 5; ) begin
      en = 1'($urandom_range(0, 1));
      applyStimulus(en, 0, 0, 16'h0);
      if (en) k++;
    end
    applyStimulus(0, 0, 0, 16'h0);
    cap_mode = 0;
    checkOutput("gated_count", cap_cnt, 64);

    for (int i = 0; i < 2000; i++)
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 31) == 0), rand_sample());

    // Flush with three samples in flight plus one on the flush edge
    repeat (5) applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(1, 1, 0, 16'h8000);
    applyStimulus(1, 1, 0, 16'h4000);
    applyStimulus(1, 1, 0, 16'h2000);
    applyStimulus(1, 1, 1, 16'h1000);
    repeat (5) begin
      applyStimulus(1, 0, 0, 16'h0);
      checkOutput("flush_drop", int'(o_LOG2_VALID), 0);
    end

    // Async reset mid-stream
    applyStimulus(1, 1, 0, 16'hC000);
    applyStimulus(1, 1, 0, 16'h4000);
    applyStimulus(1, 1, 0, 16'h2000);
    applyStimulus(1, 1, 0, 16'h1000);
    applyStimulus(1, 1, 0, 16'h0800);
    checkOutput("pre_rst_valid", int'(o_LOG2_VALID), 1);
    checkOutput("pre_rst_log2",  int'($signed(o_LOG2)), 2396);
    #2 i_RSTn = 1'b0;
    #1;
    checkOutput("async_rst_valid", int'(o_LOG2_VALID), 0);
    checkOutput("async_rst_log2",  int'($signed(o_LOG2)), 0);
    checkOutput("async_rst_zero",  int'(o_ZERO), 0);
    repeat (3) applyStimulus(1, 0, 0, 16'h0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    applyStimulus(1, 1, 0, 16'h4000);
    repeat (3) begin
      applyStimulus(1, 0, 0, 16'h0);
      checkOutput("post_rst_early", int'(o_LOG2_VALID), 0);
    end
    applyStimulus(1, 0, 0, 16'h0);
    checkOutput("post_rst_valid", int'(o_LOG2_VALID), 1);
    checkOutput("post_rst_log2",  int'($signed(o_LOG2)), -4096);
    repeat (2) applyStimulus(0, 0, 0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
